// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped timer peripheral.
// Contents: data width, default base address, register offsets and the
// bit positions inside CTRL and STATUS.
package mmio_pkg;

    localparam int unsigned DataWidth = 16;

    // Default window base; the low three address bits must be zero.
    localparam logic [15:0] TimerBaseAddr = 16'hFFF0;

    // Register offsets within the 8-word window.
    localparam logic [2:0] OffCtrl     = 3'd0;
    localparam logic [2:0] OffPrescale = 3'd1;
    localparam logic [2:0] OffCount    = 3'd2;
    localparam logic [2:0] OffCompare  = 3'd3;
    localparam logic [2:0] OffStatus   = 3'd4;
    localparam logic [2:0] OffCapture  = 3'd5;

    // CTRL bit positions.
    localparam int unsigned CtrlEnBit     = 0;
    localparam int unsigned CtrlReloadBit = 1;
    localparam int unsigned CtrlIrqEnBit  = 2;

    // STATUS bit positions.
    localparam int unsigned StatMatchBit = 0;
    localparam int unsigned StatOvfBit   = 1;
    localparam int unsigned StatCaptBit  = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: divides the clock by (prescale + 1).
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_en             : count enable; when low the divider holds
//   i_prescale       : divide value (0 = tick every cycle)
//   i_clr            : restart the divider from zero
//   o_tick           : one-cycle pulse when the divider wraps
module timer_prescaler
    import mmio_pkg::*;
(
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic [DataWidth-1:0] i_prescale,
    input  logic                 i_clr,
    output logic                 o_tick
);

    logic [DataWidth-1:0] r_pcnt;
    logic [DataWidth-1:0] w_pcnt_d;

    assign o_tick = i_en & (r_pcnt == i_prescale);

    always_comb begin
        w_pcnt_d = r_pcnt;
        if (i_clr) begin
            w_pcnt_d = '0;
        end else if (i_en) begin
            w_pcnt_d = o_tick ? '0 : r_pcnt + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= w_pcnt_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer responder on the CPU data bus.
// Decodes an 8-word window at BASE_ADDR and returns registered read data with
// one cycle of latency. Holds a prescaled 16-bit up-counter, compare register,
// sticky write-1-to-clear status flags and a level interrupt.
// Optional capture input is built only when MMIO_TIMER_CAPTURE_EN is defined.
// Ports:
//   i_clock, i_reset   : clock, synchronous active-high reset
//   i_cpu_address      : CPU word address
//   i_cpu_write_enable : CPU write strobe
//   i_cpu_write_data   : CPU write data
//   i_capture_in       : asynchronous capture input (optional feature only)
//   o_read_data        : registered read data, 0 when not hit
//   o_hit              : registered window hit
//   o_irq              : STATUS.match & CTRL.irq_en
module mmio_timer
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR     = TimerBaseAddr,
    parameter logic [15:0] COMPARE_RESET = 16'hFFFF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [15:0]          i_cpu_address,
    input  logic                 i_cpu_write_enable,
    input  logic [DataWidth-1:0] i_cpu_write_data,
    input  logic                 i_capture_in,
    output logic [DataWidth-1:0] o_read_data,
    output logic                 o_hit,
    output logic                 o_irq
);

    logic [2:0]           r_ctrl;
    logic [DataWidth-1:0] r_prescale;
    logic [DataWidth-1:0] r_count;
    logic [DataWidth-1:0] r_compare;
    logic [1:0]           r_status;
    logic                 r_hit;
    logic [DataWidth-1:0] r_read_data;

    logic                 w_sel;
    logic [2:0]           w_off;
    logic                 w_wr;
    logic                 w_wr_count;
    logic                 w_wr_prescale;
    logic                 w_wr_status;
    logic                 w_tick;
    logic                 w_eq;
    logic                 w_reload;
    logic                 w_match_set;
    logic                 w_ovf_set;
    logic [DataWidth-1:0] w_count_d;
    logic [DataWidth-1:0] w_rdata;
    logic [DataWidth-1:0] w_capture_rd;
    logic                 w_capt_flag_rd;

    assign w_sel         = (i_cpu_address[15:3] == BASE_ADDR[15:3]);
    assign w_off         = i_cpu_address[2:0];
    assign w_wr          = w_sel & i_cpu_write_enable;
    assign w_wr_count    = w_wr & (w_off == OffCount);
    assign w_wr_prescale = w_wr & (w_off == OffPrescale);
    assign w_wr_status   = w_wr & (w_off == OffStatus);

    timer_prescaler u_prescaler (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_en       (r_ctrl[CtrlEnBit]),
        .i_prescale (r_prescale),
        .i_clr      (w_wr_count | w_wr_prescale),
        .o_tick     (w_tick)
    );

    // A CPU write to COUNT overrides the tick entirely, including its flag events.
    assign w_eq        = (r_count == r_compare);
    assign w_reload    = w_eq & r_ctrl[CtrlReloadBit];
    assign w_match_set = w_tick & ~w_wr_count & w_eq;
    assign w_ovf_set   = w_tick & ~w_wr_count & ~w_reload & (r_count == 16'hFFFF);

    always_comb begin
        w_count_d = r_count;
        if (w_wr_count) begin
            w_count_d = i_cpu_write_data;
        end else if (w_tick) begin
            w_count_d = w_reload ? '0 : r_count + 1'b1;
        end
    end

`ifdef MMIO_TIMER_CAPTURE_EN
    logic [1:0]           r_capt_sync;
    logic                 r_capt_prev;
    logic [DataWidth-1:0] r_capture;
    logic                 r_capt_flag;
    logic                 w_capt_edge;

    assign w_capt_edge    = r_capt_sync[1] & ~r_capt_prev;
    assign w_capture_rd   = r_capture;
    assign w_capt_flag_rd = r_capt_flag;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_capt_sync <= '0;
            r_capt_prev <= 1'b0;
            r_capture   <= '0;
            r_capt_flag <= 1'b0;
        end else begin
            r_capt_sync <= {r_capt_sync[0], i_capture_in};
            r_capt_prev <= r_capt_sync[1];
            if (w_capt_edge) begin
                r_capture <= r_count;
            end
            // Set event wins over a same-cycle write-1 clear.
            r_capt_flag <= (r_capt_flag & ~(w_wr_status & i_cpu_write_data[StatCaptBit]))
                         | w_capt_edge;
        end
    end
`else
    logic w_unused_capture;
    assign w_unused_capture = i_capture_in;
    assign w_capture_rd     = '0;
    assign w_capt_flag_rd   = 1'b0;
`endif

    // Read mux sees pre-write register values, so read-during-write returns old data.
    always_comb begin
        w_rdata = '0;
        case (w_off)
            OffCtrl:     w_rdata = {13'd0, r_ctrl};
            OffPrescale: w_rdata = r_prescale;
            OffCount:    w_rdata = r_count;
            OffCompare:  w_rdata = r_compare;
            OffStatus:   w_rdata = {13'd0, w_capt_flag_rd, r_status};
            OffCapture:  w_rdata = w_capture_rd;
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ctrl      <= '0;
            r_prescale  <= '0;
            r_count     <= '0;
            r_compare   <= COMPARE_RESET;
            r_status    <= '0;
            r_hit       <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_hit       <= w_sel;
            r_read_data <= w_sel ? w_rdata : '0;
            r_count     <= w_count_d;
            if (w_wr && w_off == OffCtrl) begin
                r_ctrl <= i_cpu_write_data[2:0];
            end
            if (w_wr_prescale) begin
                r_prescale <= i_cpu_write_data;
            end
            if (w_wr && w_off == OffCompare) begin
                r_compare <= i_cpu_write_data;
            end
            r_status[StatMatchBit] <= (r_status[StatMatchBit]
                                       & ~(w_wr_status & i_cpu_write_data[StatMatchBit]))
                                      | w_match_set;
            r_status[StatOvfBit]   <= (r_status[StatOvfBit]
                                       & ~(w_wr_status & i_cpu_write_data[StatOvfBit]))
                                      | w_ovf_set;
        end
    end

    assign o_hit       = r_hit;
    assign o_read_data = r_read_data;
    assign o_irq       = r_status[StatMatchBit] & r_ctrl[CtrlIrqEnBit];

endmodule
